uart_io_ctrl: RTL and testbench

Memory-mapped I/O controller that sits between the MIPS150 datapath's load/store port and the UART ready/valid interfaces. It decouples CPU accesses from serial timing with a TX FIFO and an RX FIFO. It exposes status and data registers at a fixed I/O base address and returns load data one cycle after the access, matching data-memory read timing.

---
 rtl/uart_io_ctrl_if.sv | 29 ++
 rtl/uart_io_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_io_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_ctrl_if.sv
// uart_io_ctrl_if: CPU load/store port plus UART ready/valid pairs.
// The slave modport is the controller. The master modport is whoever drives
// both the CPU side and the UART side, such as a datapath wrapper or a bench.
interface uart_io_ctrl_if;
  logic        stall;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  modport master (
    output stall, addr, wr_en, rd_en, wdata,
    output uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );

  modport slave (
    input  stall, addr, wr_en, rd_en, wdata,
    input  uart_tx_ready, uart_rx_data, uart_rx_valid,
    output rdata, uart_tx_data, uart_tx_valid, uart_rx_ready
  );
endinterface

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: memory-mapped UART controller with TX and RX byte FIFOs.
// Load data is registered, so it appears one cycle after the access.
// Optional build macro IO_CYCLE_COUNTER_EN adds a 32-bit free-running cycle
// counter at offset 0x10. A write to 0x10 clears the counter.
module uart_io_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 4,
  parameter int          RX_DEPTH  = 4
) (
  input logic           clk,
  input logic           rst,
  uart_io_ctrl_if.slave bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW+1)'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);

  localparam logic [7:0] OFF_TX_STAT = 8'h00;
  localparam logic [7:0] OFF_RX_STAT = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_RX_DATA = 8'h0C;
`ifdef IO_CYCLE_COUNTER_EN
  localparam logic [7:0] OFF_CYCLES  = 8'h10;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [TX_AW:0]   tx_count_reg;
  logic [RX_AW:0]   rx_count_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      rd_value;

  logic       hit, cpu_ok;
  logic [7:0] offset;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;

  // Decode and FIFO handshakes. Full and empty come only from registered
  // state, so a same-cycle pop never makes room for a same-cycle push.
  assign hit      = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign cpu_ok   = hit && !bus.stall && !rst;
  assign offset   = bus.addr[7:0];
  assign tx_full  = (tx_count_reg == TX_FULL_CNT);
  assign tx_empty = (tx_count_reg == '0);
  assign rx_full  = (rx_count_reg == RX_FULL_CNT);
  assign rx_empty = (rx_count_reg == '0);

  assign tx_push = cpu_ok && bus.wr_en && (offset == OFF_TX_DATA) && !tx_full;
  assign tx_pop  = !tx_empty && bus.uart_tx_ready;
  assign rx_push = bus.uart_rx_valid && !rx_full;
  assign rx_pop  = cpu_ok && bus.rd_en && (offset == OFF_RX_DATA) && !rx_empty;

  assign bus.uart_tx_valid = !tx_empty;
  assign bus.uart_tx_data  = tx_mem[tx_rd_ptr_reg];
  assign bus.uart_rx_ready = !rx_full;
  assign bus.rdata         = rdata_reg;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_count_reg;
  logic        cycle_clr;
  assign cycle_clr = cpu_ok && bus.wr_en && (offset == OFF_CYCLES);

  // Free-running counter. It ignores stall, and an effective write clears it.
  always_ff @(posedge clk) begin
    if (rst || cycle_clr) cycle_count_reg <= '0;
    else                  cycle_count_reg <= cycle_count_reg + 32'd1;
  end
`endif

  // Read mux for the register map. Unmapped offsets and misses return 0.
  always_comb begin
    rd_value = 32'd0;
    if (hit) begin
      case (offset)
        OFF_TX_STAT: rd_value = {16'd0, 8'(tx_count_reg), 7'd0, !tx_full};
        OFF_RX_STAT: rd_value = {16'd0, 8'(rx_count_reg), 7'd0, !rx_empty};
        OFF_RX_DATA: if (!rx_empty) rd_value = {24'd0, rx_mem[rx_rd_ptr_reg]};
`ifdef IO_CYCLE_COUNTER_EN
        OFF_CYCLES:  rd_value = cycle_count_reg;
`endif
        default:     rd_value = 32'd0;
      endcase
    end
  end

  // Registered load data. It holds its value unless a non-stalled load occurs.
  always_ff @(posedge clk) begin
    if (rst)                             rdata_reg <= 32'd0;
    else if (bus.rd_en && !bus.stall)    rdata_reg <= rd_value;
  end

  // FIFO data arrays (no reset; contents are qualified by the counts)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= bus.wdata;
    if (rx_push && !rst) rx_mem[rx_wr_ptr_reg] <= bus.uart_rx_data;
  end

  // TX pointers and count. A simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + TX_CNT_ONE;
        2'b01:   tx_count_reg <= tx_count_reg - TX_CNT_ONE;
        default: tx_count_reg <= tx_count_reg;
      endcase
    end
  end

  // RX pointers and count. Reset wins, so a byte presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + RX_CNT_ONE;
        2'b01:   rx_count_reg <= rx_count_reg - RX_CNT_ONE;
        default: rx_count_reg <= rx_count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb_uart_io_ctrl: a vector table covers reset/decode/TX fill, and
// hand-written sequences cover the multi-cycle FIFO corners. A queue
// scoreboard holds expected load data and expected TX bytes.
module tb_uart_io_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_io_ctrl_if bus_if();

  uart_io_ctrl #(
    .BASE_ADDR(BASE),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int vec_count  = 0;
  int miss_count = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [7:0]  wdata;
    logic        tx_accept;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access cycle. Load data is checked one edge later against the scoreboard.
  task automatic cpu_op(input logic [31:0] a, input logic w, input logic r,
                        input logic [7:0] d, input logic s, input logic [31:0] exp,
                        input string name);
    logic [31:0] e;
    bus_if.addr  = a;
    bus_if.wr_en = w;
    bus_if.rd_en = r;
    bus_if.wdata = d;
    bus_if.stall = s;
    if (r) rd_q.push_back(exp);
    tick();
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.stall = 1'b0;
    if (r) begin
      e = rd_q.pop_front();
      check(name, bus_if.rdata, e);
    end
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    cpu_op(BASE | {24'd0, off}, 1'b0, 1'b1, 8'h00, 1'b0, exp, name);
  endtask

  task automatic wr_tx(input logic [7:0] d, input logic accept);
    if (accept) tx_q.push_back(d);
    cpu_op(BASE | 32'h08, 1'b1, 1'b0, d, 1'b0, 32'd0, "");
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check(name, tx_q.size(), 0);
  endtask

  // TX monitor: a byte leaves whenever valid && ready at the coming edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && bus_if.uart_tx_valid && bus_if.uart_tx_ready) begin
      if (tx_q.size() == 0) begin
        vec_count++;
        miss_count++;
        $display("FAIL tx_unexpected: got 0x%02h, expected no byte", bus_if.uart_tx_data);
      end else begin
        e = tx_q.pop_front();
        check("tx_byte", {24'd0, bus_if.uart_tx_data}, {24'd0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.stall = 1'b0;
    bus_if.addr = BASE;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.wdata = 8'h00;
    bus_if.uart_tx_ready = 1'b0;
    bus_if.uart_rx_data = 8'h00;
    bus_if.uart_rx_valid = 1'b0;

    //              addr            wr    rd    wdata  txacc exp
    vecs[0]  = '{BASE | 32'h00,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_0001};
    vecs[1]  = '{BASE | 32'h04,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_0000};
    vecs[2]  = '{32'h7000_0008,   1'b1, 1'b0, 8'h99, 1'b0, 32'h0};
    vecs[3]  = '{BASE | 32'h00,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_0001};
    vecs[4]  = '{BASE | 32'h08,   1'b1, 1'b0, 8'h41, 1'b1, 32'h0};
    vecs[5]  = '{BASE | 32'h08,   1'b1, 1'b0, 8'h42, 1'b1, 32'h0};
    vecs[6]  = '{BASE | 32'h08,   1'b1, 1'b0, 8'h43, 1'b1, 32'h0};
    vecs[7]  = '{BASE | 32'h08,   1'b1, 1'b0, 8'h44, 1'b1, 32'h0};
    vecs[8]  = '{BASE | 32'h08,   1'b1, 1'b0, 8'h45, 1'b0, 32'h0};
    vecs[9]  = '{BASE | 32'h00,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0000_0400};
    vecs[10] = '{BASE | 32'h14,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
    vecs[11] = '{32'h9000_0000,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
    vecs[12] = '{BASE | 32'h0C,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0};
    vecs[13] = '{BASE | 32'h08,   1'b0, 1'b1, 8'h00, 1'b0, 32'h0};

    tick();
    tick();
    rst = 1'b0;
    check("reset_tx_valid", {31'd0, bus_if.uart_tx_valid}, 32'd0);
    check("reset_rx_ready", {31'd0, bus_if.uart_rx_ready}, 32'd1);
    check("reset_rdata", bus_if.rdata, 32'd0);

    // Table: status reads, decode misses, and TX fill past full while ready=0
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].tx_accept) tx_q.push_back(vecs[i].wdata);
      cpu_op(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, 1'b0, vecs[i].exp,
             $sformatf("vec%0d_addr%08h", i, vecs[i].addr));
    end
    check("tx_head_valid", {31'd0, bus_if.uart_tx_valid}, 32'd1);
    check("tx_head_data", {24'd0, bus_if.uart_tx_data}, 32'h41);

    // Drain 0x41..0x44; 0x45 must never appear
    bus_if.uart_tx_ready = 1'b1;
    wait_tx_drain("tx_drain_fill");
    tick();
    check("tx_empty_after_drain", {31'd0, bus_if.uart_tx_valid}, 32'd0);

    // Store into an empty FIFO: the byte becomes visible the next cycle
    bus_if.addr = BASE | 32'h08;
    bus_if.wdata = 8'h61;
    bus_if.wr_en = 1'b1;
    tx_q.push_back(8'h61);
    #1;
    check("tx_valid_same_cycle", {31'd0, bus_if.uart_tx_valid}, 32'd0);
    tick();
    bus_if.wr_en = 1'b0;
    check("tx_valid_next_cycle", {31'd0, bus_if.uart_tx_valid}, 32'd1);
    check("tx_data_next_cycle", {24'd0, bus_if.uart_tx_data}, 32'h61);
    // A push and a pop in the same cycle leave the count at 1
    wr_tx(8'h62, 1'b1);
    bus_if.uart_tx_ready = 1'b0;
    rd(8'h00, 32'h0000_0101, "tx_stat_push_pop");
    // Fill to full, then store while draining: the store is dropped
    wr_tx(8'h63, 1'b1);
    wr_tx(8'h64, 1'b1);
    wr_tx(8'h65, 1'b1);
    bus_if.uart_tx_ready = 1'b1;
    wr_tx(8'h66, 1'b0);
    bus_if.uart_tx_ready = 1'b0;
    rd(8'h00, 32'h0000_0301, "tx_stat_full_store_drain");
    bus_if.uart_tx_ready = 1'b1;
    wait_tx_drain("tx_drain_wrap");

    // RX: two bytes in, read back in order, then read while empty
    bus_if.uart_rx_valid = 1'b1;
    bus_if.uart_rx_data = 8'h5A;
    tick();
    bus_if.uart_rx_data = 8'hA5;
    tick();
    bus_if.uart_rx_valid = 1'b0;
    rd(8'h04, 32'h0000_0201, "rx_stat_two");
    rd(8'h0C, 32'h0000_005A, "rx_data_first");
    rd(8'h0C, 32'h0000_00A5, "rx_data_second");
    rd(8'h0C, 32'h0000_0000, "rx_data_empty");
    rd(8'h04, 32'h0000_0000, "rx_stat_empty");

    // RX full with a fifth byte held; it enters the cycle after a pop
    bus_if.uart_rx_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus_if.uart_rx_data = 8'h11 + 8'(b);
      tick();
    end
    bus_if.uart_rx_data = 8'h77;
    check("rx_ready_full", {31'd0, bus_if.uart_rx_ready}, 32'd0);
    rd(8'h04, 32'h0000_0401, "rx_stat_full");
    bus_if.addr = BASE | 32'h0C;
    bus_if.rd_en = 1'b1;
    rd_q.push_back(32'h11);
    #1;
    check("rx_ready_during_pop", {31'd0, bus_if.uart_rx_ready}, 32'd0);
    tick();
    bus_if.rd_en = 1'b0;
    check("rx_pop_full", bus_if.rdata, rd_q.pop_front());
    check("rx_ready_after_pop", {31'd0, bus_if.uart_rx_ready}, 32'd1);
    tick();
    bus_if.uart_rx_valid = 1'b0;
    check("rx_ready_refilled", {31'd0, bus_if.uart_rx_ready}, 32'd0);
    rd(8'h04, 32'h0000_0401, "rx_stat_refilled");
    rd(8'h0C, 32'h12, "rx_data_12");
    rd(8'h0C, 32'h13, "rx_data_13");
    rd(8'h0C, 32'h14, "rx_data_14");
    rd(8'h0C, 32'h77, "rx_data_77");

    // Stall: a stalled RX read neither pops nor updates rdata; a stalled store is lost
    bus_if.uart_rx_valid = 1'b1;
    bus_if.uart_rx_data = 8'h33;
    tick();
    bus_if.uart_rx_valid = 1'b0;
    cpu_op(BASE | 32'h0C, 1'b0, 1'b1, 8'h00, 1'b1, 32'h77, "rx_read_stalled");
    rd(8'h04, 32'h0000_0101, "rx_stat_after_stall");
    rd(8'h0C, 32'h33, "rx_read_unstalled");
    cpu_op(BASE | 32'h08, 1'b1, 1'b0, 8'h99, 1'b1, 32'd0, "");
    tick();
    check("tx_store_stalled", {31'd0, bus_if.uart_tx_valid}, 32'd0);

    // Reset mid-transfer discards both FIFOs and ignores the RX byte shown during reset
    bus_if.uart_tx_ready = 1'b0;
    wr_tx(8'hEE, 1'b0);
    bus_if.uart_rx_valid = 1'b1;
    bus_if.uart_rx_data = 8'h44;
    tick();
    rst = 1'b1;
    bus_if.uart_rx_data = 8'h88;
    tick();
    tick();
    rst = 1'b0;
    bus_if.uart_rx_valid = 1'b0;
    check("midrst_tx_valid", {31'd0, bus_if.uart_tx_valid}, 32'd0);
    check("midrst_rx_ready", {31'd0, bus_if.uart_rx_ready}, 32'd1);
    check("midrst_rdata", bus_if.rdata, 32'd0);
    bus_if.uart_tx_ready = 1'b1;
    tick();
    tick();
    rd(8'h04, 32'h0000_0000, "midrst_rx_stat");
    rd(8'h00, 32'h0000_0001, "midrst_tx_stat");

`ifdef IO_CYCLE_COUNTER_EN
    cpu_op(BASE | 32'h10, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0, "");
    repeat (10) tick();
    rd(8'h10, 32'd10, "cycle_counter");
`else
    rd(8'h10, 32'd0, "cycle_counter_absent");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
